ysyx_23060111_mem_arb: RTL and testbench

- Two-master, one-slave memory arbiter with valid/ready handshakes on every channel.
- Shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (load/store, read/write).
- Serialises the two masters, allowing one outstanding transaction at a time.
- LSU has default priority; a starvation counter guarantees IFU forward progress. Sits between IFU/LSU and ysyx_23060111_mem in the top level.

---
 rtl/ysyx_23060111_mem_arb.sv | 135 +++++++++++++
 tb/tb_ysyx_23060111_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060111_mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory arbiter with one outstanding transaction.
// LSU wins by default; a starvation counter forces an IFU grant after STARVE_LIMIT LSU wins.
module ysyx_23060111_mem_arb #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            owner,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              owner_q;
  logic [AW-1:0]     addr_q;
  logic              wen_q;
  logic [DW-1:0]     wdata_q;
  logic [DW/8-1:0]   wmask_q;
  logic [DW-1:0]     rdata_q;
  logic              grant_lsu, grant_ifu;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == LIMIT) ? cnt : cnt + 4'd1;
  endfunction

  always_comb begin
    state_nxt      = state;
    grant_lsu      = 1'b0;
    grant_ifu      = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        grant_lsu     = lsu_req_valid && ((starve_cnt != LIMIT) || !ifu_req_valid);
        grant_ifu     = !grant_lsu && ifu_req_valid;
        lsu_req_ready = grant_lsu;
        ifu_req_ready = grant_ifu;
        if (grant_lsu || grant_ifu) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        mem_resp_ready = 1'b1;
        if (mem_resp_valid) state_nxt = DELIVER;
      end
      DELIVER: begin
        lsu_resp_valid = owner_q;
        ifu_resp_valid = !owner_q;
        if (owner_q ? lsu_resp_ready : ifu_resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Request capture at grant time; response capture on the WAIT handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (grant_lsu) begin
        owner_q <= 1'b1;
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
        if (ifu_req_valid) starve_cnt <= sat_inc(starve_cnt);
      end else if (grant_ifu) begin
        owner_q    <= 1'b0;
        addr_q     <= ifu_addr;
        wen_q      <= 1'b0;
        wdata_q    <= '0;
        wmask_q    <= '0;
        starve_cnt <= 4'd0;
      end
      if (state == WAIT && mem_resp_valid) rdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;
  assign owner     = owner_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060111_mem_arb.sv
// Directed self-checking bench for the IFU/LSU memory arbiter with a 1-cycle memory model.
module tb_ysyx_23060111_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        owner, busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] log_addr[$];
  logic        log_wen[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_wmask[$];
  bit          grants[$];

  ysyx_23060111_mem_arb #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h8000_0004) ? 32'h0000_9117 : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory: logs each accepted request and answers one cycle later.
  always @(posedge clk) begin : mem_model
    logic        fire, taken;
    logic [31:0] a;
    fire  = mem_req_valid && mem_req_ready;
    taken = mem_resp_valid && mem_resp_ready;
    a     = mem_addr;
    if (fire) begin
      log_addr.push_back(mem_addr);
      log_wen.push_back(mem_wen);
      log_wdata.push_back(mem_wdata);
      log_wmask.push_back(mem_wmask);
    end
    #1;
    if (taken || !rst) mem_resp_valid = 1'b0;
    if (fire && rst) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = mem_data(a);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int cyc = 0;
    while (busy && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic collect_grants(input int want, input bit one_shot, input int budget);
    int cyc = 0;
    bit drop_i, drop_l;
    while (grants.size() < want && cyc < budget) begin
      drop_i = 0;
      drop_l = 0;
      @(negedge clk);
      if (lsu_req_valid && lsu_req_ready) begin grants.push_back(1'b1); drop_l = one_shot; end
      if (ifu_req_valid && ifu_req_ready) begin grants.push_back(1'b0); drop_i = one_shot; end
      tick();
      if (drop_l) lsu_req_valid = 1'b0;
      if (drop_i) ifu_req_valid = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", owner); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
    checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_resp_ready: got %b want 0", mem_resp_ready); end
    checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", {ifu_resp_valid, lsu_resp_valid}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_fields: got %h want 0", {mem_addr, mem_wdata}); end
    checks++; if ({mem_wen, mem_wmask} !== 5'h0) begin errors++; $display("FAIL reset_wen_wmask: got %h want 0", {mem_wen, mem_wmask}); end
    checks++; if (ifu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ifu_rdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ifu_read();
    ifu_resp_ready = 1'b0;
    tick();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin errors++; $display("FAIL ifu_grant_ready: got %b want 10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL ifu_issue_valid: got %b want 1", mem_req_valid); end
    checks++; if (mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL ifu_issue_addr: got %h want 80000004", mem_addr); end
    checks++; if ({mem_wen, mem_wmask} !== 5'h0) begin errors++; $display("FAIL ifu_issue_wen_wmask: got %h want 0", {mem_wen, mem_wmask}); end
    checks++; if ({busy, owner} !== 2'b10) begin errors++; $display("FAIL ifu_busy_owner: got %b want 10", {busy, owner}); end
    tick();
    checks++; if ({mem_resp_ready, ifu_resp_valid} !== 2'b10) begin errors++; $display("FAIL ifu_wait: got %b want 10", {mem_resp_ready, ifu_resp_valid}); end
    checks++; if ({mem_wen, mem_wmask} !== 5'h0) begin errors++; $display("FAIL ifu_wait_wen_wmask: got %h want 0", {mem_wen, mem_wmask}); end
    tick();
    checks++; if ({ifu_resp_valid, lsu_resp_valid} !== 2'b10) begin errors++; $display("FAIL ifu_deliver_valid: got %b want 10", {ifu_resp_valid, lsu_resp_valid}); end
    checks++; if (ifu_rdata !== 32'h0000_9117) begin errors++; $display("FAIL ifu_rdata: got %h want 00009117", ifu_rdata); end
    ifu_resp_ready = 1'b1;
    tick();
    checks++; if ({busy, ifu_resp_valid} !== 2'b00) begin errors++; $display("FAIL ifu_done: got %b want 00", {busy, ifu_resp_valid}); end
  endtask

  task automatic test_lsu_write();
    int n0;
    lsu_resp_ready = 1'b0;
    n0 = log_addr.size();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_0040;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'h0000_9117;
    lsu_wmask     = 4'b1111;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL lsu_grant_ready: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
    tick();
    lsu_req_valid = 1'b0;
    checks++; if ({mem_req_valid, mem_wen, owner} !== 3'b111) begin errors++; $display("FAIL lsu_issue_ctrl: got %b want 111", {mem_req_valid, mem_wen, owner}); end
    checks++; if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_0040, 32'h0000_9117, 4'hF}) begin errors++; $display("FAIL lsu_issue_fields: got %h", {mem_addr, mem_wdata, mem_wmask}); end
    tick();
    checks++; if (lsu_resp_valid !== 1'b0) begin errors++; $display("FAIL lsu_wait_resp: got %b want 0", lsu_resp_valid); end
    tick();
    checks++; if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin errors++; $display("FAIL lsu_deliver_valid: got %b want 10", {lsu_resp_valid, ifu_resp_valid}); end
    checks++; if (log_addr.size() !== n0 + 1) begin errors++; $display("FAIL lsu_req_count: got %0d want %0d", log_addr.size(), n0 + 1); end
    checks++; if ({log_addr[n0], log_wen[n0], log_wdata[n0], log_wmask[n0]} !== {32'h8000_0040, 1'b1, 32'h0000_9117, 4'hF}) begin
      errors++; $display("FAIL lsu_mem_fields: got %h", {log_addr[n0], log_wen[n0], log_wdata[n0], log_wmask[n0]});
    end
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    lsu_wen        = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsu_done: got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    int n0;
    n0 = log_addr.size();
    grants.delete();
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_0100;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0200;
    collect_grants(2, 1'b1, 50);
    wait_idle(50);
    checks++; if (grants.size() !== 2) begin errors++; $display("FAIL sim_grant_count: got %0d want 2", grants.size()); end
    checks++; if ({grants[0], grants[1]} !== 2'b10) begin errors++; $display("FAIL sim_grant_order: got %b want 10", {grants[0], grants[1]}); end
    checks++; if (log_addr.size() !== n0 + 2) begin errors++; $display("FAIL sim_req_count: got %0d want %0d", log_addr.size(), n0 + 2); end
    checks++; if ({log_addr[n0], log_addr[n0+1]} !== {32'h8000_0100, 32'h8000_0200}) begin
      errors++; $display("FAIL sim_addr_order: got %h want 8000010080000200", {log_addr[n0], log_addr[n0+1]});
    end
  endtask

  task automatic test_starvation();
    bit exp;
    grants.delete();
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    collect_grants(10, 1'b0, 300);
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b0;
    wait_idle(50);
    checks++; if (grants.size() !== 10) begin errors++; $display("FAIL starve_grant_count: got %0d want 10", grants.size()); end
    for (int i = 0; i < 10; i++) begin
      exp = (i == 4 || i == 9) ? 1'b0 : 1'b1;
      checks++; if (grants[i] !== exp) begin errors++; $display("FAIL starve_grant_%0d: got %b want %b", i, grants[i], exp); end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    n0 = log_addr.size();
    mem_req_ready  = 1'b0;
    lsu_resp_ready = 1'b0;
    ifu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0300;
    lsu_req_valid  = 1'b1;
    lsu_addr       = 32'h8000_2000;
    lsu_wen        = 1'b0;
    #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin errors++; $display("FAIL bp_grant: got %b want 01", {ifu_req_ready, lsu_req_ready}); end
    tick();
    lsu_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({mem_req_valid, mem_addr, mem_wen, ifu_req_ready} !== {1'b1, 32'h8000_2000, 1'b0, 1'b0}) begin
        errors++; $display("FAIL bp_issue_%0d: got %h", i, {mem_req_valid, mem_addr, mem_wen, ifu_req_ready});
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({lsu_resp_valid, lsu_rdata, ifu_req_ready} !== {1'b1, 32'h25A5_2000, 1'b0}) begin
        errors++; $display("FAIL bp_deliver_%0d: got %h", i, {lsu_resp_valid, lsu_rdata, ifu_req_ready});
      end
      tick();
    end
    checks++; if (log_addr.size() !== n0 + 1) begin errors++; $display("FAIL bp_req_count: got %0d want %0d", log_addr.size(), n0 + 1); end
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
    #1;
    checks++; if ({busy, ifu_req_ready} !== 2'b01) begin errors++; $display("FAIL bp_next_grant: got %b want 01", {busy, ifu_req_ready}); end
    tick();
    ifu_req_valid = 1'b0;
    wait_idle(20);
    checks++; if (log_addr[log_addr.size()-1] !== 32'h8000_0300) begin errors++; $display("FAIL bp_ifu_addr: got %h want 80000300", log_addr[log_addr.size()-1]); end
  endtask

  task automatic test_reset_mid();
    bit          seen = 0;
    logic [31:0] got = '0;
    ifu_resp_ready = 1'b0;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0400;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_wait: got %b want 1", mem_resp_ready); end
    rst = 1'b0;
    #1;
    checks++; if ({busy, mem_req_valid, mem_resp_ready} !== 3'b000) begin errors++; $display("FAIL rmid_ctrl: got %b want 000", {busy, mem_req_valid, mem_resp_ready}); end
    checks++; if ({ifu_resp_valid, lsu_resp_valid, owner} !== 3'b000) begin errors++; $display("FAIL rmid_resp: got %b want 000", {ifu_resp_valid, lsu_resp_valid, owner}); end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    ifu_resp_ready = 1'b1;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_0000;
    #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_regrant: got %b want 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ifu_resp_valid) begin seen = 1; got = ifu_rdata; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rmid_resp_timeout: got %b want 1", seen); end
    checks++; if (got !== 32'h25A5_0000) begin errors++; $display("FAIL rmid_rdata: got %h want 25a50000", got); end
  endtask

  initial begin
    ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; lsu_resp_ready = 0;
    mem_req_ready = 1; mem_resp_valid = 0; mem_rdata = '0;
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
